// File: rtl/stage_ctrl_fsm.sv
// Multi-cycle fetch/decode/execute control FSM with req/ack memory handshake and timeout trap.
// Optional CTRL_PERF_CNT_EN adds cycle and retired-instruction counters.
module stage_ctrl_fsm #(
  parameter int unsigned TIMEOUT = 12,
  parameter int unsigned TO_W    = 4
) (
  input  logic        CLK,
  input  logic        reset,
  input  logic [3:0]  opcode,
  input  logic        cond_true,
  input  logic        mem_ack,
  output logic        mem_req,
  output logic        mem_we,
  output logic        pc_src,
  output logic        irw,
  output logic        ccw,
  output logic        pcw,
  output logic        regw,
  output logic        alu_src_imm,
  output logic        halted,
  output logic        fault,
  output logic [2:0]  state_o
`ifdef CTRL_PERF_CNT_EN
  ,
  output logic [31:0] cyc_cnt,
  output logic [31:0] ret_cnt
`endif
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5,
    S_FAULT  = 3'd6
  } state_e;

  typedef enum logic [3:0] {
    OP_ADD  = 4'h0,
    OP_SUB  = 4'h1,
    OP_ADDI = 4'h2,
    OP_LW   = 4'h3,
    OP_SW   = 4'h4,
    OP_BR   = 4'h5,
    OP_J    = 4'h6,
    OP_CMP  = 4'h7,
    OP_HALT = 4'hF
  } op_e;

  state_e          r_state;
  state_e          w_next;
  logic            r_run;
  logic [TO_W-1:0] r_cnt;
  op_e             r_op;
  logic            w_req;
  logic            w_ack;
  logic            w_timeout;

  // r_run holds off the first request after reset so a stale ack cannot complete a fetch.
  always_comb begin
    w_req     = r_run && (r_state == S_FETCH || r_state == S_MEM);
    w_ack     = w_req && mem_ack;
    w_timeout = w_req && !mem_ack && (r_cnt == TO_W'(TIMEOUT));
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_FETCH: begin
        if (w_ack)          w_next = S_DECODE;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_DECODE: begin
        case (opcode)
          OP_ADD, OP_SUB, OP_ADDI, OP_LW,
          OP_SW, OP_BR, OP_J, OP_CMP: w_next = S_EXEC;
          OP_HALT:                    w_next = S_HALT;
          default:                    w_next = S_FAULT;
        endcase
      end
      S_EXEC: begin
        case (r_op)
          OP_ADD, OP_SUB, OP_ADDI: w_next = S_WB;
          OP_LW, OP_SW:            w_next = S_MEM;
          default:                 w_next = S_FETCH;
        endcase
      end
      S_MEM: begin
        if (w_ack)          w_next = (r_op == OP_LW) ? S_WB : S_FETCH;
        else if (w_timeout) w_next = S_FAULT;
      end
      S_WB:    w_next = S_FETCH;
      default: w_next = r_state;
    endcase
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_state <= S_FETCH;
      r_run   <= 1'b0;
      r_cnt   <= '0;
      r_op    <= OP_ADD;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_next;
      if (r_state == S_DECODE) r_op <= op_e'(opcode);
      if (w_next != r_state || w_ack)  r_cnt <= '0;
      else if (w_req && r_cnt != '1)   r_cnt <= r_cnt + 1'b1;
    end
  end

  // Ack-qualified enables are decoded from the current state so the access completes in its ack cycle.
  always_comb begin
    mem_req     = w_req;
    mem_we      = (r_state == S_MEM) && (r_op == OP_SW);
    irw         = (r_state == S_FETCH) && w_ack;
    pcw         = ((r_state == S_FETCH) && w_ack) ||
                  ((r_state == S_EXEC) && ((r_op == OP_J) || (r_op == OP_BR && cond_true)));
    pc_src      = (r_state == S_EXEC) && (r_op == OP_BR || r_op == OP_J);
    ccw         = (r_state == S_EXEC) && (r_op == OP_CMP);
    regw        = (r_state == S_WB);
    alu_src_imm = (r_state == S_EXEC) && (r_op == OP_ADDI || r_op == OP_LW || r_op == OP_SW);
    halted      = (r_state == S_HALT);
    fault       = (r_state == S_FAULT);
    state_o     = r_state;
  end

`ifdef CTRL_PERF_CNT_EN
  logic [31:0] r_cyc;
  logic [31:0] r_ret;
  logic        w_retire;

  always_comb begin
    w_retire = (r_state == S_WB) ||
               ((r_state == S_EXEC) && (r_op == OP_CMP || r_op == OP_BR || r_op == OP_J)) ||
               ((r_state == S_MEM) && w_ack && (r_op == OP_SW));
  end

  always_ff @(posedge CLK or posedge reset) begin
    if (reset) begin
      r_cyc <= '0;
      r_ret <= '0;
    end else begin
      if (r_state != S_HALT && r_state != S_FAULT) r_cyc <= r_cyc + 32'd1;
      if (w_retire)                                r_ret <= r_ret + 32'd1;
    end
  end

  assign cyc_cnt = r_cyc;
  assign ret_cnt = r_ret;
`endif

endmodule

// File: tb/tb_stage_ctrl_fsm.sv
// Directed bench for stage_ctrl_fsm: expected output vectors are queued ahead and popped each cycle.
module tb_stage_ctrl_fsm;

  logic        CLK = 1'b0;
  logic        reset;
  logic [3:0]  opcode;
  logic        cond_true;
  logic        mem_ack;
  logic        mem_req, mem_we, pc_src, irw, ccw, pcw, regw, alu_src_imm, halted, fault;
  logic [2:0]  state_o;
`ifdef CTRL_PERF_CNT_EN
  logic [31:0] cyc_cnt, ret_cnt;
`endif

  stage_ctrl_fsm #(.TIMEOUT(12), .TO_W(4)) dut (
    .CLK(CLK), .reset(reset), .opcode(opcode), .cond_true(cond_true), .mem_ack(mem_ack),
    .mem_req(mem_req), .mem_we(mem_we), .pc_src(pc_src), .irw(irw), .ccw(ccw), .pcw(pcw),
    .regw(regw), .alu_src_imm(alu_src_imm), .halted(halted), .fault(fault), .state_o(state_o)
`ifdef CTRL_PERF_CNT_EN
    , .cyc_cnt(cyc_cnt), .ret_cnt(ret_cnt)
`endif
  );

  always #5 CLK = ~CLK;

  localparam logic [12:0] REQ  = 13'h1000;
  localparam logic [12:0] WE   = 13'h0800;
  localparam logic [12:0] PCS  = 13'h0400;
  localparam logic [12:0] IRW  = 13'h0200;
  localparam logic [12:0] CCW  = 13'h0100;
  localparam logic [12:0] PCW  = 13'h0080;
  localparam logic [12:0] REGW = 13'h0040;
  localparam logic [12:0] IMM  = 13'h0020;
  localparam logic [12:0] HLT  = 13'h0010;
  localparam logic [12:0] FLT  = 13'h0008;

  logic [12:0] obs;
  assign obs = {mem_req, mem_we, pc_src, irw, ccw, pcw, regw, alu_src_imm, halted, fault, state_o};

  logic [12:0] exp_q[$];
  string       tag_q[$];
  int          tests = 0;
  int          fails = 0;

  task automatic push(input string t, input logic [12:0] v);
    exp_q.push_back(v);
    tag_q.push_back(t);
  endtask

  task automatic pop_check();
    logic [12:0] e;
    string       t;
    tests++;
    if (exp_q.size() == 0) begin
      fails++;
      $display("FAIL scoreboard_empty: observed %h expected <none>", obs);
    end else begin
      e = exp_q.pop_front();
      t = tag_q.pop_front();
      assert (obs === e) else begin
        fails++;
        $error("FAIL %s: observed %h expected %h", t, obs, e);
      end
    end
  endtask

  task automatic cyc(input logic ack, input logic cond);
    @(negedge CLK);
    mem_ack   = ack;
    cond_true = cond;
    #1;
    pop_check();
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2;
    reset   = 1'b1;
    mem_ack = 1'b0;
    #1;
    push("reset_outputs", 13'h0000);
    pop_check();
`ifdef CTRL_PERF_CNT_EN
    tests++;
    assert (cyc_cnt === 32'd0 && ret_cnt === 32'd0) else begin
      fails++;
      $error("FAIL perf_reset: observed %h/%h expected 0/0", cyc_cnt, ret_cnt);
    end
`endif
    @(negedge CLK);
    reset   = 1'b0;
    mem_ack = 1'b1;
    #1;
    push("post_reset_ack_ignored", 13'h0000);
    pop_check();
  endtask

  task automatic fd(input logic [3:0] op, input string t);
    opcode = op;
    push({t, "_fetch"}, REQ | IRW | PCW | 13'd0);
    push({t, "_decode"}, 13'd1);
    cyc(1'b1, 1'b0);
    cyc(1'b0, 1'b0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b1;
    opcode    = 4'h0;
    cond_true = 1'b0;
    mem_ack   = 1'b0;
    do_reset();

    fd(4'h0, "add");
    push("add_exec", 13'd2);
    push("add_wb", REGW | 13'd4);
    cyc(0, 0); cyc(0, 0);

    fd(4'h1, "sub");
    push("sub_exec", 13'd2);
    push("sub_wb", REGW | 13'd4);
    cyc(0, 0); cyc(0, 0);

    fd(4'h2, "addi");
    push("addi_exec", IMM | 13'd2);
    push("addi_wb", REGW | 13'd4);
    cyc(0, 0); cyc(0, 0);

    fd(4'h3, "lw");
    push("lw_exec", IMM | 13'd2);
    for (int i = 0; i < 3; i++) push("lw_mem_wait", REQ | 13'd3);
    push("lw_mem_ack", REQ | 13'd3);
    push("lw_wb", REGW | 13'd4);
    cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0); cyc(1, 0); cyc(0, 0);

    fd(4'h4, "sw");
    push("sw_exec", IMM | 13'd2);
    push("sw_mem", REQ | WE | 13'd3);
    cyc(0, 0); cyc(1, 0);

    fd(4'h5, "br_nt");
    push("br_nt_exec", PCS | 13'd2);
    cyc(0, 0);

    fd(4'h5, "br_t");
    push("br_t_exec", PCS | PCW | 13'd2);
    cyc(0, 1);

    fd(4'h6, "j");
    push("j_exec", PCS | PCW | 13'd2);
    cyc(0, 0);

    fd(4'h7, "cmp");
    push("cmp_exec", CCW | 13'd2);
    push("cmp_next_fetch", REQ | 13'd0);
    cyc(0, 0); cyc(0, 0);

    fd(4'h9, "illegal");
    push("illegal_fault", FLT | 13'd6);
    push("illegal_fault_sticky", FLT | 13'd6);
    cyc(0, 0); cyc(1, 0);
    do_reset();

    fd(4'h3, "lw_rst");
    push("lw_rst_exec", IMM | 13'd2);
    push("lw_rst_mem", REQ | 13'd3);
    cyc(0, 0); cyc(0, 0);
    do_reset();

    fd(4'hF, "halt");
    push("halt_state", HLT | 13'd5);
    push("halt_no_req", HLT | 13'd5);
    cyc(1, 0); cyc(1, 0);
    do_reset();

    opcode = 4'h0;
    for (int i = 0; i < 12; i++) push("fetch_wait", REQ | 13'd0);
    push("ack_at_timeout_wins", REQ | IRW | PCW | 13'd0);
    push("ack_at_timeout_decode", 13'd1);
    push("ack_at_timeout_exec", 13'd2);
    push("ack_at_timeout_wb", REGW | 13'd4);
    for (int i = 0; i < 12; i++) cyc(0, 0);
    cyc(1, 0); cyc(0, 0); cyc(0, 0); cyc(0, 0);

    for (int i = 0; i < 13; i++) push("timeout_wait", REQ | 13'd0);
    push("timeout_fault", FLT | 13'd6);
    push("timeout_fault_sticky", FLT | 13'd6);
    for (int i = 0; i < 14; i++) cyc(0, 0);
    cyc(1, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
